// File: rtl/bcd_score_counter.sv
// Synchronous N-digit BCD score counter with inc/dec, clear, clamped load, wrap/saturate and win decode.
// Optional leading-zero blanking output is built when BCD_SCORE_BLANK_EN is defined.
module bcd_score_counter #(
  parameter int                    DIGITS  = 2,
  parameter int                    WRAP    = 1,
  parameter logic [4*DIGITS-1:0]   WIN_BCD = 'h11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  inc,
  input  logic                  dec,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry,
  output logic                  borrow,
`ifdef BCD_SCORE_BLANK_EN
  output logic                  win,
  output logic [DIGITS-1:0]     blank
`else
  output logic                  win
`endif
);

  logic [4*DIGITS-1:0] inc_val;
  logic [4*DIGITS-1:0] dec_val;
  logic [4*DIGITS-1:0] load_clamped;
  logic [4*DIGITS-1:0] bcd_next;
  logic                inc_chain;
  logic                dec_chain;
  logic                all_nines;
  logic                all_zero;
  logic                carry_next;
  logic                borrow_next;
  logic                win_next;

  // Ripple the +1 through the digits; a chain still live past the top digit means all-9s.
  always_comb begin
    inc_val   = bcd;
    inc_chain = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (inc_chain) begin
        if (bcd[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = bcd[4*k +: 4] + 4'd1;
          inc_chain         = 1'b0;
        end
      end
    end
    all_nines = inc_chain;
  end

  always_comb begin
    dec_val   = bcd;
    dec_chain = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (dec_chain) begin
        if (bcd[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = bcd[4*k +: 4] - 4'd1;
          dec_chain         = 1'b0;
        end
      end
    end
    all_zero = dec_chain;
  end

  always_comb begin
    load_clamped = load_val;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) begin
        load_clamped[4*k +: 4] = 4'd9;
      end
    end
  end

  // clr beats load beats counting; inc and dec together cancel out.
  always_comb begin
    bcd_next    = bcd;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    if (clr) begin
      bcd_next = '0;
    end else if (load) begin
      bcd_next = load_clamped;
    end else if (inc && !dec) begin
      if (!all_nines) begin
        bcd_next = inc_val;
      end else if (WRAP != 0) begin
        bcd_next   = inc_val;
        carry_next = 1'b1;
      end
    end else if (dec && !inc) begin
      if (!all_zero) begin
        bcd_next = dec_val;
      end else if (WRAP != 0) begin
        bcd_next    = dec_val;
        borrow_next = 1'b1;
      end
    end
    win_next = (bcd_next == WIN_BCD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd    <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
      win    <= (WIN_BCD == '0);
    end else begin
      bcd    <= bcd_next;
      carry  <= carry_next;
      borrow <= borrow_next;
      win    <= win_next;
    end
  end

`ifdef BCD_SCORE_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic              upper_zero;

  // A digit blanks only when it and everything above it are zero; digit 0 always shows.
  always_comb begin
    blank_next = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero    = upper_zero && (bcd_next[4*k +: 4] == 4'd0);
      blank_next[k] = upper_zero;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blank <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      blank <= blank_next;
    end
  end
`endif

endmodule
